// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard stream -> toggle-strobed 11-bit ps2_key event word.
// Pipeline: 2-flop synchronisers, clock glitch filter, frame deserialiser,
// then a prefix stage that folds E0/F0/E1 prefixes into one event per key.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced at the stop bit).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a start bit (strobe with data 0)
// ST_SHIFT | receiving data[0..7], parity, stop (bit_cnt 0..9)

module ps2_key_encoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        rx_err,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [7:0]    filt_cnt;
    logic          filt_flip, strobe;
    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout, last_bit, par_ok, byte_ok, frame_bad, is_ack;
    logic          ext, brk;
    logic [2:0]    skip;

    // Bring the asynchronous PS/2 lines into the clk_sys domain (idle level 1).
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
        end
    end

    // Strobe is the cycle in which the filtered clock is about to fall; data is
    // taken from the synchronised data line in that same cycle.
    always_comb begin
        filt_flip = (clk_s2 != filt_clk) && (filt_cnt == 8'(FILTER_LEN - 1));
        strobe    = filt_flip && filt_clk;
        timeout   = (state == ST_SHIFT) && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        last_bit  = strobe && (state == ST_SHIFT) && (bit_cnt == 4'd9);
`ifdef PS2_PARITY_CHECK_EN
        par_ok    = ^{shreg, par_bit};
`else
        par_ok    = 1'b1;
`endif
        byte_ok   = last_bit && dat_s2 && par_ok;
        frame_bad = last_bit && !(dat_s2 && par_ok);
        is_ack    = (shreg == 8'hAA) || (shreg == 8'hFA) || (shreg == 8'hEE) || (shreg == 8'hFE);
        busy      = (state == ST_SHIFT);
    end

    // Glitch filter: level changes only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // Frame deserialiser: start bit, 8 data bits LSB first, parity, stop.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (strobe && !dat_s2) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    if (strobe) begin
                        if (bit_cnt < 4'd8) shreg <= {dat_s2, shreg[7:1]};
                        if (bit_cnt == 4'd8) par_bit <= dat_s2;
                        if (bit_cnt == 4'd9) state <= ST_IDLE;
                        else bit_cnt <= bit_cnt + 4'd1;
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Inactivity timer; a strobe always wins over an expiry in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (strobe || timeout || state == ST_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Error pulse for a bad stop/parity or an aborted partial frame.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) rx_err <= 1'b0;
        else          rx_err <= frame_bad || timeout;
    end

    // Prefix stage: fold E0/F0, swallow the E1 pause sequence, drop ack-style bytes.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (byte_ok) begin
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
            end else if (shreg == 8'hE0) begin
                ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
            end else if (shreg == 8'hE1) begin
                skip <= 3'd7;
            end else if (!(is_ack && !ext && !brk)) begin
                ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: frames are bit-banged on the PS/2 pins,
// expected event words are hand-derived constants plus a local toggle-bit tracker.
module tb_ps2_key_encoder;

    localparam int FL = 4;
    localparam int TO = 200;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        rx_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_fall = 0;
    int err_pulses = 0;
    int toggles = 0;
    bit busy_seen = 0;
    logic prev_t = 1'b0;
    logic exp_t = 1'b0;

    ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in), .ps2_key(ps2_key), .rx_err(rx_err), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge.
    always @(negedge clk_sys) begin
        if (rx_err === 1'b1) err_pulses++;
        if (ps2_key[10] !== prev_t) toggles++;
        prev_t = ps2_key[10];
        if (busy === 1'b1) busy_seen = 1;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys) ps2_data_in = bits[i];
            repeat (10) @(negedge clk_sys);
            ps2_clk_in = 1'b0;
            last_fall = cyc;
            repeat (20) @(negedge clk_sys);
            ps2_clk_in = 1'b1;
            repeat (10) @(negedge clk_sys);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 0, 0), 11);
        ps2_data_in = 1'b1;
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (4) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++; if (ps2_key !== 11'h000) begin n_bad++; $display("FAIL reset_key got=%h want=000", ps2_key); end
        n_cmp++; if (rx_err !== 1'b0) begin n_bad++; $display("FAIL reset_rx_err got=%b want=0", rx_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_make;
        int e0;
        e0 = err_pulses;
        send_byte(8'h1C);
        exp_t = ~exp_t;
        n_cmp++; if (ps2_key !== 11'h61C) begin n_bad++; $display("FAIL make_1c got=%h want=61c", ps2_key); end
        n_cmp++; if (err_pulses !== e0) begin n_bad++; $display("FAIL make_rx_err got=%0d want=%0d", err_pulses, e0); end
    endtask

    task automatic test_ext_break;
        int t0;
        t0 = toggles;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        exp_t = ~exp_t;
        n_cmp++; if (toggles - t0 !== 1) begin n_bad++; $display("FAIL extbrk_toggles got=%0d want=1", toggles - t0); end
        n_cmp++; if (ps2_key !== {exp_t, 10'h16B}) begin n_bad++; $display("FAIL extbrk_word got=%h want=%h", ps2_key, {exp_t, 10'h16B}); end
        send_byte(8'h1C);
        exp_t = ~exp_t;
        n_cmp++; if (ps2_key !== {exp_t, 10'h21C}) begin n_bad++; $display("FAIL extbrk_flags_cleared got=%h want=%h", ps2_key, {exp_t, 10'h21C}); end
    endtask

    task automatic test_pause;
        int t0;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        t0 = toggles;
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        n_cmp++; if (toggles !== t0) begin n_bad++; $display("FAIL pause_silent got=%0d want=%0d", toggles, t0); end
        send_byte(8'h1C);
        exp_t = ~exp_t;
        n_cmp++; if (ps2_key !== {exp_t, 10'h21C}) begin n_bad++; $display("FAIL pause_after got=%h want=%h", ps2_key, {exp_t, 10'h21C}); end
    endtask

    task automatic test_parity;
        int e0;
        logic [10:0] k0;
        e0 = err_pulses;
        k0 = ps2_key;
        send_bits(make_frame(8'h55, 1, 0), 11);
        ps2_data_in = 1'b1;
        repeat (10) @(negedge clk_sys);
`ifdef PS2_PARITY_CHECK_EN
        n_cmp++; if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL parity_err got=%0d want=1", err_pulses - e0); end
        n_cmp++; if (ps2_key !== k0) begin n_bad++; $display("FAIL parity_key got=%h want=%h", ps2_key, k0); end
`else
        exp_t = ~exp_t;
        n_cmp++; if (err_pulses - e0 !== 0) begin n_bad++; $display("FAIL parity_err got=%0d want=0", err_pulses - e0); end
        n_cmp++; if (ps2_key !== {exp_t, 10'h255}) begin n_bad++; $display("FAIL parity_key got=%h want=%h", ps2_key, {exp_t, 10'h255}); end
`endif
    endtask

    task automatic test_stop_err;
        int e0;
        logic [10:0] k0;
        e0 = err_pulses;
        k0 = ps2_key;
        send_bits(make_frame(8'h33, 0, 1), 11);
        ps2_data_in = 1'b1;
        repeat (10) @(negedge clk_sys);
        n_cmp++; if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL stop_err got=%0d want=1", err_pulses - e0); end
        n_cmp++; if (ps2_key !== k0) begin n_bad++; $display("FAIL stop_key got=%h want=%h", ps2_key, k0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy got=%b want=0", busy); end
    endtask

    task automatic test_timeout;
        int e0, d;
        bit got;
        logic [10:0] k0;
        e0 = err_pulses;
        k0 = ps2_key;
        got = 0;
        send_bits(make_frame(8'h29, 0, 0), 5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_busy_before got=%b want=1", busy); end
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk_sys);
            if (rx_err === 1'b1) got = 1;
        end
        d = cyc - last_fall;
        n_cmp++; if (!got || d < TO || d > TO + FL + 6) begin n_bad++; $display("FAIL timeout_delay got=%0d seen=%0d want=%0d..%0d", d, got, TO, TO + FL + 6); end
        repeat (3) @(negedge clk_sys);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy_after got=%b want=0", busy); end
        n_cmp++; if (err_pulses - e0 !== 1 || ps2_key !== k0) begin n_bad++; $display("FAIL timeout_pulse got=%0d key=%h want=1 key=%h", err_pulses - e0, ps2_key, k0); end
        ps2_data_in = 1'b1;
        repeat (10) @(negedge clk_sys);
        send_byte(8'h29);
        exp_t = ~exp_t;
        n_cmp++; if (ps2_key !== {exp_t, 10'h229}) begin n_bad++; $display("FAIL timeout_next got=%h want=%h", ps2_key, {exp_t, 10'h229}); end
    endtask

    task automatic test_glitch;
        int t0;
        t0 = toggles;
        busy_seen = 0;
        @(negedge clk_sys);
        ps2_data_in = 1'b0;
        ps2_clk_in = 1'b0;
        repeat (FL - 1) @(negedge clk_sys);
        ps2_clk_in = 1'b1;
        repeat (20) @(negedge clk_sys);
        ps2_data_in = 1'b1;
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL glitch_busy got=%b want=0", busy_seen); end
        n_cmp++; if (toggles !== t0) begin n_bad++; $display("FAIL glitch_toggle got=%0d want=%0d", toggles, t0); end
    endtask

    task automatic test_reset_mid;
        send_bits(make_frame(8'hE0, 0, 0), 11);
        send_bits(make_frame(8'h1C, 0, 0), 4);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        n_cmp++; if (ps2_key !== 11'h000 || rx_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_outputs got=%h/%b/%b want=000/0/0", ps2_key, rx_err, busy); end
        exp_t = 1'b0;
        ps2_data_in = 1'b1;
        repeat (10) @(negedge clk_sys);
        send_byte(8'h1C);
        exp_t = ~exp_t;
        n_cmp++; if (ps2_key !== 11'h61C) begin n_bad++; $display("FAIL rstmid_next got=%h want=61c", ps2_key); end
    endtask

    initial begin
        test_reset;
        test_make;
        test_ext_break;
        test_pause;
        test_parity;
        test_stop_err;
        test_timeout;
        test_glitch;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
